dps_bus_arbiter: RTL and testbench
==================================

Name: dps_bus_arbiter

Overview:
- Shares the single default_peripheral_system register port (REQ/BUSY/RW/ADDR/DATA, VALID/DATA return) between two masters: M0 = CPU core load/store path, M1 = debug/boot-loader path.
- Round-robin arbitration and a one-entry registered output stage toward the DPS.
- An in-order read-tag FIFO routes each oDPS_VALID/oDPS_DATA return to the master that issued the read.
- Sits between the core bus interface and default_peripheral_system.

Parameters:
P_ADDR_W, 32, address width
P_DATA_W, 32, data width
P_RD_DEPTH, 4, max reads in flight (output stage + issued to DPS, awaiting VALID); power of two, >=2

Ports:
iCLOCK  in  1  system clock
iRESET  in  1  asynchronous reset, active-high
iM0_REQ  in  1  M0 request; held with fields stable while oM0_BUSY=1
oM0_BUSY  out  1  1 = M0 request not accepted this cycle
iM0_RW  in  1  1 = write, 0 = read
iM0_ADDR  in  P_ADDR_W  M0 address
iM0_DATA  in  P_DATA_W  M0 write data
oM0_VALID  out  1  read data valid for M0, 1-cycle pulse
oM0_DATA  out  P_DATA_W  read data for M0
iM1_REQ, oM1_BUSY, iM1_RW, iM1_ADDR, iM1_DATA, oM1_VALID, oM1_DATA  same as M0, for M1
oDPS_REQ  out  1  request to DPS, held until accepted
iDPS_BUSY  in  1  DPS not accepting
oDPS_RW  out  1  to DPS
oDPS_ADDR  out  P_ADDR_W  to DPS
oDPS_DATA  out  P_DATA_W  to DPS
iDPS_VALID  in  1  DPS read return
iDPS_DATA  in  P_DATA_W  DPS read data
oRD_PENDING  out  clog2(P_RD_DEPTH)+1  reads in flight
oERR  out  1  sticky: iDPS_VALID received with no read in flight

Behaviour:
- Reset (async, iRESET=1):
  - oDPS_REQ=0; oDPS_RW/ADDR/DATA=0.
  - oMx_VALID=0, oMx_DATA=0; oRD_PENDING=0; oERR=0.
  - RR pointer=M0; tag FIFO empty.
  - oMx_BUSY is combinational and reads 1 while iRESET=1.
- Acceptance at DPS: oDPS_REQ && !iDPS_BUSY on a rising edge.
- Output stage is loadable when !oDPS_REQ, or when it is accepted this cycle.
- Eligibility: master x is eligible when iMx_REQ && loadable && (iMx_RW || rd_count < P_RD_DEPTH). A pop in the same cycle does not free a slot.
- Grant (combinational):
  - Only one eligible master: it is granted.
  - Both eligible: the master named by the RR pointer is granted.
  - After any grant, the RR pointer moves to the other master.
  - oMx_BUSY = !grant_x.
- On grant (registered, 1-cycle latency):
  - Output stage loads RW/ADDR/DATA; oDPS_REQ=1.
  - On a read grant, the master id is pushed into the tag FIFO and rd_count increments.
- oDPS_REQ drops after acceptance unless a new grant reloads the stage the same edge. Back-to-back accepted requests reach the DPS every cycle when iDPS_BUSY=0.
- iDPS_BUSY held high: the stage holds its value unchanged and both oMx_BUSY=1.
- Writes produce no response and use no tag.
- Read return:
  - On iDPS_VALID with FIFO non-empty: pop the head id; the next cycle drive oM[id]_VALID=1 and oM[id]_DATA=iDPS_DATA; rd_count decrements.
  - The other master's VALID stays 0; oMx_DATA holds its last value.
- Same-cycle push and pop: both happen; rd_count unchanged.
- iDPS_VALID with FIFO empty: no VALID to either master; oERR=1 until reset.
- Returns are strictly in issue order; the DPS guarantees in-order completion.
- Reset mid-operation: all state is cleared. DPS returns arriving after reset set oERR, and the integration layer resets the DPS with the arbiter.
- oRD_PENDING = rd_count.

Decomposition:
- Shared package dps_bus_pkg: master-id encoding (M0=0, M1=1), RW encoding (1=write), P_RD_DEPTH default.
- One sub-module: dps_tag_fifo. Parameterised depth, 1-bit entries; push, pop, full, empty, count; async active-high reset.

Test Plan:
- Single write: M0 write addr 0x00000000 data 0x1, DPS idle -> oM0_BUSY=0 that cycle; next cycle oDPS_REQ=1, oDPS_ADDR=0x0, oDPS_DATA=0x1, oDPS_RW=1; oRD_PENDING stays 0.
- Contention: M0 and M1 both write (0x08, 0x0C) every cycle for 4 cycles, DPS never busy -> DPS sees M0, M1, M0, M1 order; each master busy on alternate cycles.
- Read routing: M1 read 0x40 then M0 read 0x2C; DPS returns 0xAAAA0001 then 0x0000000F -> oM1_VALID with 0xAAAA0001, then oM0_VALID with 0x0000000F, each one cycle after iDPS_VALID.
- Read limit: iDPS_VALID held 0; M0 issues 5 reads -> first 4 granted, oRD_PENDING=4, 5th held busy; one VALID -> 5th granted the following cycle.
- Backpressure: iDPS_BUSY=1 for 3 cycles with stage loaded 0x2C/0xF -> oDPS_* stable, both oMx_BUSY=1; on release, accepted once, no duplicate.
- Error/reset: iDPS_VALID with nothing pending -> oERR=1, no oMx_VALID. Then assert iRESET mid-read -> all outputs at reset values, oERR=0.

Source files
------------

// File: rtl/dps_bus_pkg.sv
// Shared encodings for the two-master default_peripheral_system arbiter.
package dps_bus_pkg;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_id_e;

    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } rw_e;

    localparam int RD_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/dps_tag_fifo.sv
// In-order FIFO of 1-bit master ids, one entry per read in flight toward the DPS.
module dps_tag_fifo #(
    parameter int P_DEPTH = 4
) (
    input  logic                     iCLOCK,
    input  logic                     iRESET,
    input  logic                     iPUSH,
    input  logic                     iPUSH_ID,
    input  logic                     iPOP,
    output logic                     oPOP_ID,
    output logic                     oFULL,
    output logic                     oEMPTY,
    output logic [$clog2(P_DEPTH):0] oCOUNT
);

    localparam int AW = $clog2(P_DEPTH);

    logic          mem_q [P_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign oFULL   = (count_q == (AW+1)'(P_DEPTH));
    assign oEMPTY  = (count_q == '0);
    assign oCOUNT  = count_q;
    assign oPOP_ID = mem_q[rd_ptr_q];
    assign do_push = iPUSH && !oFULL;
    assign do_pop  = iPOP && !oEMPTY;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; validity comes from the pointers.
    always_ff @(posedge iCLOCK) begin
        if (do_push) mem_q[wr_ptr_q] <= iPUSH_ID;
    end

endmodule

// File: rtl/dps_bus_arbiter.sv
// Round-robin arbiter sharing the DPS register port between the CPU (M0) and
// debug/boot (M1) masters, with read returns routed back by an in-order tag FIFO.
module dps_bus_arbiter
    import dps_bus_pkg::*;
#(
    parameter int P_ADDR_W   = 32,
    parameter int P_DATA_W   = 32,
    parameter int P_RD_DEPTH = RD_DEPTH_DEFAULT
) (
    input  logic                        iCLOCK,
    input  logic                        iRESET,
    input  logic                        iM0_REQ,
    output logic                        oM0_BUSY,
    input  logic                        iM0_RW,
    input  logic [P_ADDR_W-1:0]         iM0_ADDR,
    input  logic [P_DATA_W-1:0]         iM0_DATA,
    output logic                        oM0_VALID,
    output logic [P_DATA_W-1:0]         oM0_DATA,
    input  logic                        iM1_REQ,
    output logic                        oM1_BUSY,
    input  logic                        iM1_RW,
    input  logic [P_ADDR_W-1:0]         iM1_ADDR,
    input  logic [P_DATA_W-1:0]         iM1_DATA,
    output logic                        oM1_VALID,
    output logic [P_DATA_W-1:0]         oM1_DATA,
    output logic                        oDPS_REQ,
    input  logic                        iDPS_BUSY,
    output logic                        oDPS_RW,
    output logic [P_ADDR_W-1:0]         oDPS_ADDR,
    output logic [P_DATA_W-1:0]         oDPS_DATA,
    input  logic                        iDPS_VALID,
    input  logic [P_DATA_W-1:0]         iDPS_DATA,
    output logic [$clog2(P_RD_DEPTH):0] oRD_PENDING,
    output logic                        oERR
);

    localparam int CW = $clog2(P_RD_DEPTH) + 1;

    logic                loadable;
    logic                elig0;
    logic                elig1;
    logic                gnt0;
    logic                gnt1;
    logic                push;
    logic                pop;
    logic                rd_full;
    logic                rd_empty;
    logic                head_id;
    logic [CW-1:0]       rd_count;
    mst_id_e             rr_q;
    mst_id_e             rr_d;

    logic                req_q;
    logic                rw_q;
    logic [P_ADDR_W-1:0] addr_q;
    logic [P_DATA_W-1:0] data_q;
    logic                m0_valid_q;
    logic                m1_valid_q;
    logic [P_DATA_W-1:0] m0_data_q;
    logic [P_DATA_W-1:0] m1_data_q;
    logic                err_q;

    // The stage frees up on the same edge it is accepted, giving one request per cycle.
    assign loadable = !req_q || !iDPS_BUSY;
    assign elig0    = iM0_REQ && loadable && (iM0_RW == RW_WRITE || !rd_full);
    assign elig1    = iM1_REQ && loadable && (iM1_RW == RW_WRITE || !rd_full);
    assign gnt0     = !iRESET && elig0 && (!elig1 || rr_q == MST_M0);
    assign gnt1     = !iRESET && elig1 && (!elig0 || rr_q == MST_M1);
    assign oM0_BUSY = !gnt0;
    assign oM1_BUSY = !gnt1;

    assign push = (gnt0 && iM0_RW == RW_READ) || (gnt1 && iM1_RW == RW_READ);
    assign pop  = iDPS_VALID && !rd_empty;

    always_comb begin
        rr_d = rr_q;
        if (gnt0)      rr_d = MST_M1;
        else if (gnt1) rr_d = MST_M0;
    end

    dps_tag_fifo #(
        .P_DEPTH (P_RD_DEPTH)
    ) u_tag_fifo (
        .iCLOCK   (iCLOCK),
        .iRESET   (iRESET),
        .iPUSH    (push),
        .iPUSH_ID (gnt1),
        .iPOP     (pop),
        .oPOP_ID  (head_id),
        .oFULL    (rd_full),
        .oEMPTY   (rd_empty),
        .oCOUNT   (rd_count)
    );

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rr_q       <= MST_M0;
            req_q      <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            m0_valid_q <= 1'b0;
            m1_valid_q <= 1'b0;
            m0_data_q  <= '0;
            m1_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q <= rr_d;
            if (gnt0) begin
                req_q  <= 1'b1;
                rw_q   <= iM0_RW;
                addr_q <= iM0_ADDR;
                data_q <= iM0_DATA;
            end else if (gnt1) begin
                req_q  <= 1'b1;
                rw_q   <= iM1_RW;
                addr_q <= iM1_ADDR;
                data_q <= iM1_DATA;
            end else if (req_q && !iDPS_BUSY) begin
                req_q <= 1'b0;
            end
            m0_valid_q <= pop && (head_id == MST_M0);
            m1_valid_q <= pop && (head_id == MST_M1);
            if (pop && head_id == MST_M0) m0_data_q <= iDPS_DATA;
            if (pop && head_id == MST_M1) m1_data_q <= iDPS_DATA;
            if (iDPS_VALID && rd_empty) err_q <= 1'b1;
        end
    end

    assign oDPS_REQ    = req_q;
    assign oDPS_RW     = rw_q;
    assign oDPS_ADDR   = addr_q;
    assign oDPS_DATA   = data_q;
    assign oM0_VALID   = m0_valid_q;
    assign oM1_VALID   = m1_valid_q;
    assign oM0_DATA    = m0_data_q;
    assign oM1_DATA    = m1_data_q;
    assign oRD_PENDING = rd_count;
    assign oERR        = err_q;

endmodule

// File: tb/tb_dps_bus_arbiter.sv
// Scenario bench for dps_bus_arbiter: expected DPS transactions and read returns are queued as stimulus is driven.
module tb_dps_bus_arbiter;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } dps_t;

    typedef struct packed {
        logic        mst;
        logic [31:0] data;
    } ret_t;

    logic        clk = 1'b0;
    logic        iRESET;
    logic        iM0_REQ, iM0_RW, iM1_REQ, iM1_RW;
    logic [31:0] iM0_ADDR, iM0_DATA, iM1_ADDR, iM1_DATA;
    logic        oM0_BUSY, oM0_VALID, oM1_BUSY, oM1_VALID;
    logic [31:0] oM0_DATA, oM1_DATA;
    logic        oDPS_REQ, iDPS_BUSY, oDPS_RW, iDPS_VALID;
    logic [31:0] oDPS_ADDR, oDPS_DATA, iDPS_DATA;
    logic [2:0]  oRD_PENDING;
    logic        oERR;

    int   n_cmp = 0;
    int   n_err = 0;
    dps_t exp_dps[$];
    ret_t exp_ret[$];
    logic rd_mst[$];
    dps_t e;
    ret_t r;

    always #5 clk = ~clk;

    dps_bus_arbiter #(
        .P_ADDR_W   (32),
        .P_DATA_W   (32),
        .P_RD_DEPTH (4)
    ) dut (
        .iCLOCK      (clk),
        .iRESET      (iRESET),
        .iM0_REQ     (iM0_REQ),
        .oM0_BUSY    (oM0_BUSY),
        .iM0_RW      (iM0_RW),
        .iM0_ADDR    (iM0_ADDR),
        .iM0_DATA    (iM0_DATA),
        .oM0_VALID   (oM0_VALID),
        .oM0_DATA    (oM0_DATA),
        .iM1_REQ     (iM1_REQ),
        .oM1_BUSY    (oM1_BUSY),
        .iM1_RW      (iM1_RW),
        .iM1_ADDR    (iM1_ADDR),
        .iM1_DATA    (iM1_DATA),
        .oM1_VALID   (oM1_VALID),
        .oM1_DATA    (oM1_DATA),
        .oDPS_REQ    (oDPS_REQ),
        .iDPS_BUSY   (iDPS_BUSY),
        .oDPS_RW     (oDPS_RW),
        .oDPS_ADDR   (oDPS_ADDR),
        .oDPS_DATA   (oDPS_DATA),
        .iDPS_VALID  (iDPS_VALID),
        .iDPS_DATA   (iDPS_DATA),
        .oRD_PENDING (oRD_PENDING),
        .oERR        (oERR)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic dps_return(input logic [31:0] d);
        logic m;
        iDPS_VALID = 1'b1;
        iDPS_DATA  = d;
        m = rd_mst.pop_front();
        exp_ret.push_back({m, d});
    endtask

    task automatic test_reset;
        iRESET = 1'b1;
        iM0_REQ = 1'b1; iM0_RW = 1'b1; iM0_ADDR = 32'h4; iM0_DATA = 32'h5;
        iM1_REQ = 1'b1; iM1_RW = 1'b1; iM1_ADDR = 32'h8; iM1_DATA = 32'h9;
        iDPS_BUSY = 1'b0; iDPS_VALID = 1'b0; iDPS_DATA = '0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA} !== 66'h0) begin n_err++; $display("FAIL rst_dps: got %h want 0", {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA}); end
        n_cmp++; if ({oM0_BUSY, oM1_BUSY} !== 2'b11) begin n_err++; $display("FAIL rst_busy: got %b want 11", {oM0_BUSY, oM1_BUSY}); end
        n_cmp++; if ({oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, oRD_PENDING, oERR} !== 70'h0) begin n_err++; $display("FAIL rst_outs: got %h want 0", {oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, oRD_PENDING, oERR}); end
        iM0_REQ = 1'b0; iM1_REQ = 1'b0;
        iRESET = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention;
        logic m0_wins;
        iM0_REQ = 1'b1; iM0_RW = 1'b1; iM0_ADDR = 32'h08; iM0_DATA = 32'h100;
        iM1_REQ = 1'b1; iM1_RW = 1'b1; iM1_ADDR = 32'h0C; iM1_DATA = 32'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            m0_wins = (k % 2 == 0);
            n_cmp++; if ({oM0_BUSY, oM1_BUSY} !== {!m0_wins, m0_wins}) begin n_err++; $display("FAIL rr_busy%0d: got %b want %b", k, {oM0_BUSY, oM1_BUSY}, {!m0_wins, m0_wins}); end
            exp_dps.push_back(m0_wins ? dps_t'({1'b1, 32'h08, 32'h100}) : dps_t'({1'b1, 32'h0C, 32'h200}));
            tick();
            if (k == 3) begin iM0_REQ = 1'b0; iM1_REQ = 1'b0; end
            e = exp_dps.pop_front();
            n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA} !== {1'b1, e}) begin n_err++; $display("FAIL rr_dps%0d: got %h want %h", k, {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA}, {1'b1, e}); end
        end
        tick();
        n_cmp++; if ({oDPS_REQ, oRD_PENDING} !== 4'h0) begin n_err++; $display("FAIL rr_idle: got %h want 0", {oDPS_REQ, oRD_PENDING}); end
    endtask

    task automatic test_single_write;
        iM0_REQ = 1'b1; iM0_RW = 1'b1; iM0_ADDR = 32'h0; iM0_DATA = 32'h1;
        #1;
        n_cmp++; if (oM0_BUSY !== 1'b0) begin n_err++; $display("FAIL sw_busy: got %b want 0", oM0_BUSY); end
        exp_dps.push_back({1'b1, 32'h0, 32'h1});
        tick();
        iM0_REQ = 1'b0;
        e = exp_dps.pop_front();
        n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA} !== {1'b1, e}) begin n_err++; $display("FAIL sw_dps: got %h want %h", {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA}, {1'b1, e}); end
        n_cmp++; if (oRD_PENDING !== 3'd0) begin n_err++; $display("FAIL sw_pend: got %0d want 0", oRD_PENDING); end
        tick();
        n_cmp++; if (oDPS_REQ !== 1'b0) begin n_err++; $display("FAIL sw_drop: got %b want 0", oDPS_REQ); end
    endtask

    task automatic test_read_routing;
        iM1_REQ = 1'b1; iM1_RW = 1'b0; iM1_ADDR = 32'h40; iM1_DATA = 32'h0;
        #1;
        n_cmp++; if (oM1_BUSY !== 1'b0) begin n_err++; $display("FAIL rd_m1busy: got %b want 0", oM1_BUSY); end
        exp_dps.push_back({1'b0, 32'h40, 32'h0}); rd_mst.push_back(1'b1);
        tick();
        iM1_REQ = 1'b0;
        e = exp_dps.pop_front();
        n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING} !== {1'b1, e, 3'd1}) begin n_err++; $display("FAIL rd_dps1: got %h want %h", {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING}, {1'b1, e, 3'd1}); end
        iM0_REQ = 1'b1; iM0_RW = 1'b0; iM0_ADDR = 32'h2C; iM0_DATA = 32'h0;
        #1;
        n_cmp++; if (oM0_BUSY !== 1'b0) begin n_err++; $display("FAIL rd_m0busy: got %b want 0", oM0_BUSY); end
        exp_dps.push_back({1'b0, 32'h2C, 32'h0}); rd_mst.push_back(1'b0);
        tick();
        iM0_REQ = 1'b0;
        e = exp_dps.pop_front();
        n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING} !== {1'b1, e, 3'd2}) begin n_err++; $display("FAIL rd_dps2: got %h want %h", {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING}, {1'b1, e, 3'd2}); end
        dps_return(32'hAAAA0001);
        tick();
        dps_return(32'h0000000F);
        r = exp_ret.pop_front();
        n_cmp++; if ({oM0_VALID, oM1_VALID, r.mst ? oM1_DATA : oM0_DATA} !== {!r.mst, r.mst, r.data}) begin n_err++; $display("FAIL rd_ret1: got %h want %h", {oM0_VALID, oM1_VALID, r.mst ? oM1_DATA : oM0_DATA}, {!r.mst, r.mst, r.data}); end
        n_cmp++; if (oRD_PENDING !== 3'd1) begin n_err++; $display("FAIL rd_pend1: got %0d want 1", oRD_PENDING); end
        tick();
        iDPS_VALID = 1'b0;
        r = exp_ret.pop_front();
        n_cmp++; if ({oM0_VALID, oM1_VALID, r.mst ? oM1_DATA : oM0_DATA} !== {!r.mst, r.mst, r.data}) begin n_err++; $display("FAIL rd_ret2: got %h want %h", {oM0_VALID, oM1_VALID, r.mst ? oM1_DATA : oM0_DATA}, {!r.mst, r.mst, r.data}); end
        n_cmp++; if ({oM1_DATA, oRD_PENDING} !== {32'hAAAA0001, 3'd0}) begin n_err++; $display("FAIL rd_hold: got %h want %h", {oM1_DATA, oRD_PENDING}, {32'hAAAA0001, 3'd0}); end
        tick();
        n_cmp++; if ({oM0_VALID, oM1_VALID} !== 2'b00) begin n_err++; $display("FAIL rd_pulse: got %b want 00", {oM0_VALID, oM1_VALID}); end
    endtask

    task automatic test_read_limit;
        iM0_REQ = 1'b1; iM0_RW = 1'b0; iM0_DATA = 32'h0; iM0_ADDR = 32'h100;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (oM0_BUSY !== 1'b0) begin n_err++; $display("FAIL lim_busy%0d: got %b want 0", k, oM0_BUSY); end
            exp_dps.push_back({1'b0, iM0_ADDR, 32'h0}); rd_mst.push_back(1'b0);
            tick();
            e = exp_dps.pop_front();
            n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING} !== {1'b1, e, 3'(k + 1)}) begin n_err++; $display("FAIL lim_dps%0d: got %h want %h", k, {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING}, {1'b1, e, 3'(k + 1)}); end
            iM0_ADDR = 32'h100 + 32'(4 * (k + 1));
        end
        #1;
        n_cmp++; if (oM0_BUSY !== 1'b1) begin n_err++; $display("FAIL lim_full: got %b want 1", oM0_BUSY); end
        tick();
        n_cmp++; if ({oDPS_REQ, oRD_PENDING, oM0_BUSY} !== {1'b0, 3'd4, 1'b1}) begin n_err++; $display("FAIL lim_held: got %h want %h", {oDPS_REQ, oRD_PENDING, oM0_BUSY}, {1'b0, 3'd4, 1'b1}); end
        dps_return(32'h55);
        #1;
        n_cmp++; if (oM0_BUSY !== 1'b1) begin n_err++; $display("FAIL lim_popslot: got %b want 1", oM0_BUSY); end
        tick();
        iDPS_VALID = 1'b0;
        r = exp_ret.pop_front();
        n_cmp++; if ({oM0_VALID, oM1_VALID, oM0_DATA, oRD_PENDING} !== {!r.mst, r.mst, r.data, 3'd3}) begin n_err++; $display("FAIL lim_ret: got %h want %h", {oM0_VALID, oM1_VALID, oM0_DATA, oRD_PENDING}, {!r.mst, r.mst, r.data, 3'd3}); end
        #1;
        n_cmp++; if (oM0_BUSY !== 1'b0) begin n_err++; $display("FAIL lim_5th: got %b want 0", oM0_BUSY); end
        exp_dps.push_back({1'b0, 32'h110, 32'h0}); rd_mst.push_back(1'b0);
        tick();
        iM0_REQ = 1'b0;
        e = exp_dps.pop_front();
        n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING} !== {1'b1, e, 3'd4}) begin n_err++; $display("FAIL lim_dps5: got %h want %h", {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA, oRD_PENDING}, {1'b1, e, 3'd4}); end
        for (int k = 0; k < 4; k++) begin
            dps_return(32'h60 + 32'(k));
            tick();
            r = exp_ret.pop_front();
            n_cmp++; if ({oM0_VALID, oM1_VALID, oM0_DATA} !== {!r.mst, r.mst, r.data}) begin n_err++; $display("FAIL lim_drain%0d: got %h want %h", k, {oM0_VALID, oM1_VALID, oM0_DATA}, {!r.mst, r.mst, r.data}); end
        end
        iDPS_VALID = 1'b0;
        n_cmp++; if (oRD_PENDING !== 3'd0) begin n_err++; $display("FAIL lim_empty: got %0d want 0", oRD_PENDING); end
        tick();
    endtask

    task automatic test_backpressure;
        iDPS_BUSY = 1'b1;
        iM0_REQ = 1'b1; iM0_RW = 1'b1; iM0_ADDR = 32'h2C; iM0_DATA = 32'hF;
        #1;
        n_cmp++; if (oM0_BUSY !== 1'b0) begin n_err++; $display("FAIL bp_load: got %b want 0", oM0_BUSY); end
        exp_dps.push_back({1'b1, 32'h2C, 32'hF});
        tick();
        iM0_ADDR = 32'h34; iM0_DATA = 32'h1;
        iM1_REQ = 1'b1; iM1_RW = 1'b1; iM1_ADDR = 32'h30; iM1_DATA = 32'h2;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if ({oM0_BUSY, oM1_BUSY} !== 2'b11) begin n_err++; $display("FAIL bp_busy%0d: got %b want 11", k, {oM0_BUSY, oM1_BUSY}); end
            n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA} !== {1'b1, exp_dps[0]}) begin n_err++; $display("FAIL bp_stable%0d: got %h want %h", k, {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA}, {1'b1, exp_dps[0]}); end
            tick();
        end
        iDPS_BUSY = 1'b0; iM0_REQ = 1'b0; iM1_REQ = 1'b0;
        e = exp_dps.pop_front();
        n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA} !== {1'b1, e}) begin n_err++; $display("FAIL bp_release: got %h want %h", {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA}, {1'b1, e}); end
        tick();
        n_cmp++; if (oDPS_REQ !== 1'b0) begin n_err++; $display("FAIL bp_once: got %b want 0", oDPS_REQ); end
        tick();
        n_cmp++; if (oDPS_REQ !== 1'b0) begin n_err++; $display("FAIL bp_nodup: got %b want 0", oDPS_REQ); end
    endtask

    task automatic test_error_reset;
        iDPS_VALID = 1'b1; iDPS_DATA = 32'hDEAD;
        tick();
        iDPS_VALID = 1'b0;
        n_cmp++; if ({oERR, oM0_VALID, oM1_VALID} !== 3'b100) begin n_err++; $display("FAIL err_set: got %b want 100", {oERR, oM0_VALID, oM1_VALID}); end
        tick();
        n_cmp++; if (oERR !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", oERR); end
        iM1_REQ = 1'b1; iM1_RW = 1'b0; iM1_ADDR = 32'h50;
        tick();
        iM1_REQ = 1'b0;
        n_cmp++; if ({oDPS_REQ, oRD_PENDING} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL err_rdq: got %h want %h", {oDPS_REQ, oRD_PENDING}, {1'b1, 3'd1}); end
        #2 iRESET = 1'b1;
        #1;
        n_cmp++; if ({oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA} !== 66'h0) begin n_err++; $display("FAIL mid_rst_dps: got %h want 0", {oDPS_REQ, oDPS_RW, oDPS_ADDR, oDPS_DATA}); end
        n_cmp++; if ({oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, oRD_PENDING, oERR} !== 70'h0) begin n_err++; $display("FAIL mid_rst_outs: got %h want 0", {oM0_VALID, oM1_VALID, oM0_DATA, oM1_DATA, oRD_PENDING, oERR}); end
        @(negedge clk);
        iRESET = 1'b0;
        rd_mst.delete();
        iDPS_VALID = 1'b1; iDPS_DATA = 32'h1234;
        tick();
        iDPS_VALID = 1'b0;
        n_cmp++; if ({oERR, oM0_VALID, oM1_VALID} !== 3'b100) begin n_err++; $display("FAIL err_late: got %b want 100", {oERR, oM0_VALID, oM1_VALID}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_read_routing();
        test_read_limit();
        test_backpressure();
        test_error_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
